traffic_sensor: RTL and testbench
=================================

TRAFFIC_SENSOR -- requirements
Module: traffic_sensor

Interface
- REQ-001 SHALL have parameter CLK_DIV_PERIOD, default 12_000_000, meaning clock cycles per 1 s departure tick.
- REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 120_000, meaning cycles a synchronized input must stay stable before being accepted.
- REQ-003 SHALL have parameter QUEUE_MAX, default 15, meaning the saturation value of each 4-bit vehicle queue.
- REQ-004 SHALL have one clock; reset is asynchronous and active-low; ports are clk and reset_n.
- REQ-005 clk  input  1  system clock.
- REQ-006 reset_n  input  1  asynchronous active-low reset.
- REQ-007 car_a_n  input  1  raw active-low vehicle-detect button, road A.
- REQ-008 car_b_n  input  1  raw active-low vehicle-detect button, road B.
- REQ-009 La  input  3  road A light code (GREEN=3'b101, YELLOW=3'b001, RED=3'b011).
- REQ-010 Lb  input  3  road B light code, same encoding.
- REQ-011 Ta  output  1  road A traffic present (queue_a != 0).
- REQ-012 Tb  output  1  road B traffic present (queue_b != 0).
- REQ-013 queue_a, queue_b  output  4 each  current vehicle count per road.

Function
- REQ-014 Each car_x_n SHALL pass a 2-flop synchronizer, reset to 1, before any other use.
- REQ-015 Debounced level SHALL take the synchronized value only after it differs from the current debounced level for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
- REQ-016 Arrival pulse SHALL be one cycle, on a debounced 1->0 transition; release generates nothing.
- REQ-017 Divider SHALL count 0..CLK_DIV_PERIOD-1 and wrap, emitting a one-cycle tick at CLK_DIV_PERIOD-1.
- REQ-018 Departure on road A SHALL occur on tick when La==GREEN and queue_a!=0; likewise road B with Lb. YELLOW and RED produce no departure.
- REQ-019 Queue update per road: arrival only -> +1; departure only -> -1; both in same cycle -> unchanged.
- REQ-020 Arrival at queue==QUEUE_MAX SHALL leave the queue at QUEUE_MAX (saturate, no wrap).
- REQ-021 No departure SHALL decrement below 0.
- REQ-022 Ta/Tb SHALL be derived combinationally from the queue registers, so they change in the cycle after the arrival/departure pulse.
- REQ-023 Illegal La/Lb codes SHALL be treated as not GREEN.
- REQ-024 Roads A and B SHALL be fully independent; simultaneous events on both roads are all applied.

Reset
- REQ-025 reset_n low SHALL asynchronously force queue_a=queue_b=0, Ta=Tb=0, divider=0, debounce counters=0, synchronizer and debounced levels=1.
- REQ-026 Reset asserted mid-debounce or mid-tick SHALL discard the partial count; no arrival pulse SHALL be generated by reset release.

Configuration
- REQ-027 Macro TRAFFIC_SENSOR_DEBOUNCE_EN defined: debouncer per REQ-015 is present.
- REQ-028 Macro TRAFFIC_SENSOR_DEBOUNCE_EN undefined: synchronized input feeds edge detection directly; DEBOUNCE_CYCLES is ignored; arrival occurs 3 cycles after the raw falling edge.

Structure
- REQ-029 Shared package traffic_pkg SHALL hold the GREEN/YELLOW/RED localparams, the default CLK_DIV_PERIOD, and the queue width constant (4); the controller uses the same package.
- REQ-030 Debounce logic SHALL be sub-module button_debounce (synchronizer, stability counter, debounced level, falling-edge pulse), instantiated once per road.

Verification (bench: CLK_DIV_PERIOD=10, DEBOUNCE_CYCLES=4, QUEUE_MAX=15, debounce enabled)
- REQ-031 Reset, then car_a_n held low 10 cycles -> exactly one arrival, queue_a=1, Ta=1, Tb=0.
- REQ-032 car_a_n glitches low for 2 cycles, then high -> queue_a unchanged, no arrival.
- REQ-033 queue_a=3, La=GREEN for 30 cycles -> queue_a=0 after third tick, Ta falls the following cycle; with La=RED queue_a stays 3.
- REQ-034 16 clean presses on road B -> queue_b=15 and stays 15 at the 16th; Tb=1.
- REQ-035 queue_a=2, arrival pulse coincident with tick and La=GREEN -> queue_a stays 2.
- REQ-036 reset_n pulsed low with queue_a=5, queue_b=7 -> both 0, Ta=Tb=0 immediately, no spurious arrival after release.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared constants for the traffic sensor and the light controller: light codes,
// default divider period, queue width and the saturating queue update helper.
package traffic_pkg;

   localparam logic [2:0] GREEN  = 3'b101;
   localparam logic [2:0] YELLOW = 3'b001;
   localparam logic [2:0] RED    = 3'b011;

   localparam int unsigned CLK_DIV_PERIOD_DEF = 12_000_000;
   localparam int unsigned QUEUE_W            = 4;

   typedef logic [QUEUE_W-1:0] queue_t;

   // Any code other than GREEN (including illegal ones) blocks departures.
   function automatic logic is_green(input logic [2:0] light);
      return light == GREEN;
   endfunction

   function automatic queue_t queue_next(input queue_t q, input logic arr, input logic dep,
                                         input queue_t qmax);
      queue_t r;
      r = q;
      if (arr && !dep && (q < qmax)) begin
         r = q + 1'b1;
      end else if (dep && !arr && (q != '0)) begin
         r = q - 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Active-low button conditioner: 2-flop synchronizer, optional stability filter
// (enabled by TRAFFIC_SENSOR_DEBOUNCE_EN) and a one-cycle falling-edge pulse.
module button_debounce #(
   parameter int unsigned DebounceCycles = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_ni,
   output logic fall_o
);

`ifdef TRAFFIC_SENSOR_DEBOUNCE_EN
   localparam bit DebounceEn = 1'b1;
`else
   localparam bit DebounceEn = 1'b0;
`endif

   logic sync1_q, sync2_q;
   logic level, level_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
      end else begin
         sync1_q <= btn_ni;
         sync2_q <= sync1_q;
         level_q <= level;
      end
   end

   if (DebounceEn && (DebounceCycles != 0)) begin : g_debounce
      localparam int unsigned CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;

      logic [CntW-1:0] cnt_q, cnt_d;
      logic            deb_q, deb_d;

      // Count consecutive cycles of disagreement; any agreement restarts the count.
      always_comb begin
         cnt_d = '0;
         deb_d = deb_q;
         if (sync2_q != deb_q) begin
            if (cnt_q == CntW'(DebounceCycles - 1)) begin
               deb_d = sync2_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cnt_q <= '0;
            deb_q <= 1'b1;
         end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
         end
      end

      assign level = deb_q;
   end else begin : g_bypass
      assign level = sync2_q;
   end

   assign fall_o = level_q & ~level;

endmodule

// File: rtl/traffic_sensor.sv
// Per-road vehicle queues: arrivals from debounced buttons, departures on the 1 s
// tick while the road is green. Debounce filter enabled by TRAFFIC_SENSOR_DEBOUNCE_EN.
module traffic_sensor import traffic_pkg::*; #(
   parameter int unsigned CLK_DIV_PERIOD  = CLK_DIV_PERIOD_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = 120_000,
   parameter int unsigned QUEUE_MAX       = 15
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               car_a_n,
   input  logic               car_b_n,
   input  logic [2:0]         La,
   input  logic [2:0]         Lb,
   output logic               Ta,
   output logic               Tb,
   output logic [QUEUE_W-1:0] queue_a,
   output logic [QUEUE_W-1:0] queue_b
);

   localparam int unsigned DivW = (CLK_DIV_PERIOD > 1) ? $clog2(CLK_DIV_PERIOD) : 1;

   logic [DivW-1:0] div_q, div_d;
   logic            tick;
   logic            arr_a, arr_b, dep_a, dep_b;
   queue_t          queue_a_q, queue_a_d, queue_b_q, queue_b_d;

   button_debounce #(
      .DebounceCycles(DEBOUNCE_CYCLES)
   ) u_deb_a (
      .clk_i (clk),
      .rst_ni(reset_n),
      .btn_ni(car_a_n),
      .fall_o(arr_a)
   );

   button_debounce #(
      .DebounceCycles(DEBOUNCE_CYCLES)
   ) u_deb_b (
      .clk_i (clk),
      .rst_ni(reset_n),
      .btn_ni(car_b_n),
      .fall_o(arr_b)
   );

   assign tick = (div_q == DivW'(CLK_DIV_PERIOD - 1));

   always_comb begin
      div_d     = tick ? '0 : div_q + 1'b1;
      dep_a     = tick && is_green(La) && (queue_a_q != '0);
      dep_b     = tick && is_green(Lb) && (queue_b_q != '0);
      queue_a_d = queue_next(queue_a_q, arr_a, dep_a, QUEUE_W'(QUEUE_MAX));
      queue_b_d = queue_next(queue_b_q, arr_b, dep_b, QUEUE_W'(QUEUE_MAX));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q     <= '0;
         queue_a_q <= '0;
         queue_b_q <= '0;
      end else begin
         div_q     <= div_d;
         queue_a_q <= queue_a_d;
         queue_b_q <= queue_b_d;
      end
   end

   assign queue_a = queue_a_q;
   assign queue_b = queue_b_q;
   assign Ta      = (queue_a_q != '0);
   assign Tb      = (queue_b_q != '0);

endmodule

// File: tb/tb_traffic_sensor.sv
// Self-checking bench for traffic_sensor: vector table, corner sequences and a
// randomized phase compared each cycle against a behavioural queue model.
module tb_traffic_sensor;

   localparam int unsigned P    = 10;
   localparam int unsigned N    = 4;
   localparam int unsigned QMAX = 15;
   localparam logic [2:0]  GRN  = 3'b101;
   localparam logic [2:0]  YEL  = 3'b001;
   localparam logic [2:0]  REDL = 3'b011;

`ifdef TRAFFIC_SENSOR_DEBOUNCE_EN
   localparam bit DebEn = 1'b1;
   localparam int Lat   = 7;  // 2 sync + N stable + 1 edge
`else
   localparam bit DebEn = 1'b0;
   localparam int Lat   = 3;
`endif

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic       car_a_n = 1'b1;
   logic       car_b_n = 1'b1;
   logic [2:0] La      = REDL;
   logic [2:0] Lb      = REDL;
   logic       Ta, Tb;
   logic [3:0] queue_a, queue_b;

   always #5 clk = ~clk;

   traffic_sensor #(
      .CLK_DIV_PERIOD (P),
      .DEBOUNCE_CYCLES(N),
      .QUEUE_MAX      (QMAX)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .car_a_n(car_a_n),
      .car_b_n(car_b_n),
      .La     (La),
      .Lb     (Lb),
      .Ta     (Ta),
      .Tb     (Tb),
      .queue_a(queue_a),
      .queue_b(queue_b)
   );

   int n_pass = 0;
   int n_chk  = 0;

   // Model: raw input history, window of synchronized samples, accepted level,
   // vehicle counts and edges elapsed since reset.
   bit m_h[2][2];
   bit m_win[2][N];
   bit m_deb[2];
   bit m_prev[2];
   int m_q[2];
   int m_ncyc;

   typedef struct {
      bit         a;
      bit         b;
      logic [2:0] la;
      logic [2:0] lb;
      int         cyc;
      bit         chk;
      int         qa;
      int         qb;
   } vec_t;

   vec_t vt[8];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
   endtask

   task automatic m_reset();
      for (int r = 0; r < 2; r++) begin
         m_h[r][0] = 1'b1;
         m_h[r][1] = 1'b1;
         for (int i = 0; i < N; i++) m_win[r][i] = 1'b1;
         m_deb[r]  = 1'b1;
         m_prev[r] = 1'b1;
         m_q[r]    = 0;
      end
      m_ncyc = 0;
   endtask

   task automatic m_step();
      bit         tick, s2, lvl, arr, dep, all_diff;
      bit         raw[2];
      logic [2:0] lt[2];
      raw[0] = car_a_n;
      raw[1] = car_b_n;
      lt[0]  = La;
      lt[1]  = Lb;
      tick   = (m_ncyc % P) == P - 1;
      for (int r = 0; r < 2; r++) begin
         s2  = m_h[r][1];
         lvl = DebEn ? m_deb[r] : s2;
         arr = m_prev[r] && !lvl;
         dep = tick && (lt[r] == GRN) && (m_q[r] > 0);
         if (arr && !dep) m_q[r] = (m_q[r] < QMAX) ? m_q[r] + 1 : QMAX;
         else if (dep && !arr) m_q[r] = m_q[r] - 1;
         m_prev[r] = lvl;
         // Accept a new level once the last N samples all disagree with it.
         for (int i = N - 1; i > 0; i--) m_win[r][i] = m_win[r][i-1];
         m_win[r][0] = s2;
         all_diff = 1'b1;
         for (int i = 0; i < N; i++) if (m_win[r][i] == m_deb[r]) all_diff = 1'b0;
         if (all_diff) m_deb[r] = s2;
         m_h[r][1] = m_h[r][0];
         m_h[r][0] = raw[r];
      end
      m_ncyc++;
   endtask

   task automatic cyc();
      @(posedge clk);
      if (reset_n) m_step();
      #1;
      check("queue_a", queue_a, m_q[0]);
      check("queue_b", queue_b, m_q[1]);
      check("Ta", Ta, int'(m_q[0] != 0));
      check("Tb", Tb, int'(m_q[1] != 0));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic press_a();
      car_a_n = 1'b0;
      run(10);
      car_a_n = 1'b1;
      run(10);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("rst_queue_a", queue_a, 0);
      check("rst_queue_b", queue_b, 0);
      check("rst_Ta", Ta, 0);
      check("rst_Tb", Tb, 0);
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      car_a_n = 1'b1;
      car_b_n = 1'b1;
      reset_n = 1'b1;
   endtask

   initial begin
      vt[0] = '{1'b0, 1'b1, REDL, REDL, 10, 1'b1, 1, 0};
      vt[1] = '{1'b1, 1'b1, REDL, REDL, 10, 1'b1, 1, 0};
      vt[2] = '{1'b0, 1'b1, REDL, REDL, 10, 1'b0, 0, 0};
      vt[3] = '{1'b1, 1'b1, REDL, REDL, 10, 1'b1, 2, 0};
      vt[4] = '{1'b0, 1'b1, REDL, REDL, 10, 1'b0, 0, 0};
      vt[5] = '{1'b1, 1'b1, REDL, REDL, 10, 1'b1, 3, 0};
      vt[6] = '{1'b1, 1'b1, REDL, REDL, 30, 1'b1, 3, 0};
      vt[7] = '{1'b1, 1'b1, GRN,  REDL, 30, 1'b1, 0, 0};

      m_reset();
      #1;
      check("init_queue_a", queue_a, 0);
      check("init_queue_b", queue_b, 0);
      check("init_Ta", Ta, 0);
      check("init_Tb", Tb, 0);
      @(negedge clk);
      reset_n = 1'b1;

      foreach (vt[i]) begin
         car_a_n = vt[i].a;
         car_b_n = vt[i].b;
         La      = vt[i].la;
         Lb      = vt[i].lb;
         run(vt[i].cyc);
         if (vt[i].chk) begin
            check("vec_queue_a", queue_a, vt[i].qa);
            check("vec_queue_b", queue_b, vt[i].qb);
            check("vec_Ta", Ta, int'(vt[i].qa != 0));
         end
      end

      // Short glitch: filtered when debouncing, a real press otherwise.
      La      = REDL;
      car_a_n = 1'b0;
      run(2);
      car_a_n = 1'b1;
      run(10);
      check("glitch_queue_a", queue_a, DebEn ? 0 : 1);

      // Road B saturates at QMAX.
      for (int i = 0; i < 16; i++) begin
         car_b_n = 1'b0;
         run(10);
         car_b_n = 1'b1;
         run(10);
         check("press_queue_b", queue_b, (i + 1 > QMAX) ? QMAX : i + 1);
      end
      check("sat_Tb", Tb, 1);

      // Arrival landing on a green departure tick leaves the count unchanged.
      for (int k = 0; k < 4 && m_q[0] < 2; k++) press_a();
      check("pre_coinc_queue_a", queue_a, 2);
      for (int k = 0; k < P && ((m_ncyc + Lat) % P) != 0; k++) run(1);
      La      = GRN;
      car_a_n = 1'b0;
      run(Lat);
      check("coinc_queue_a", queue_a, 2);
      La = REDL;
      run(10);
      car_a_n = 1'b1;
      run(10);
      check("coinc_after_queue_a", queue_a, 2);

      // Drain B to 7, fill A to 5, then reset mid-debounce.
      Lb = GRN;
      run(80);
      Lb = REDL;
      check("drain_queue_b", queue_b, 7);
      for (int k = 0; k < 3; k++) press_a();
      check("fill_queue_a", queue_a, 5);
      car_a_n = 1'b0;
      run(2);
      do_reset();
      run(20);
      check("post_rst_queue_a", queue_a, 0);
      check("post_rst_Ta", Ta, 0);

      // Randomized traffic, illegal light codes included.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 5) == 0) car_a_n = ~car_a_n;
         if ($urandom_range(0, 5) == 0) car_b_n = ~car_b_n;
         if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 4))
               0, 1:    La = GRN;
               2:       La = YEL;
               3:       La = REDL;
               default: La = 3'($urandom_range(0, 7));
            endcase
         end
         if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 4))
               0, 1:    Lb = GRN;
               2:       Lb = YEL;
               3:       Lb = REDL;
               default: Lb = 3'($urandom_range(0, 7));
            endcase
         end
         run(1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
